// File: rtl/vram_pkg.sv
// Shared types and default sizes for the VRAM request bridge.
package vram_pkg;

    localparam int VRAM_ADDR_W = 16;
    localparam int VRAM_DATA_W = 16;
    localparam int VRAM_DEPTH  = 4;

    // Bridge sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_REQ  = 2'd1,
        RD_REQ  = 2'd2,
        RD_WAIT = 2'd3
    } bridge_state_t;

    // One queued write: target address plus data
    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous show-ahead FIFO with wrap-bit pointers.
// A push while full is dropped even if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted push/pop; natural wrap gives modulo 2*DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Pointer registers, cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are only visible while non-empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/vram_req_bridge.sv
// Queues VRAM client writes and reads and serialises them onto a
// single-port memory request interface; read data returns via a FIFO.
module vram_req_bridge
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int DEPTH  = VRAM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] writeaddr,
    input  logic [DATA_W-1:0] writedata,
    output logic              wr_full,
    input  logic              read,
    input  logic [ADDR_W-1:0] readaddr,
    input  logic              rd_pop,
    output logic [DATA_W-1:0] readdata,
    output logic              rd_empty,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              overflow
);

    localparam int PW = $clog2(DEPTH) + 1;

    bridge_state_t     state_q, state_d;
    logic              last_wr_q, last_wr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              overflow_q, overflow_d;

    wr_entry_t         wf_din, wf_dout;
    logic              wf_full, wf_empty, wf_pop;
    logic [PW-1:0]     wf_count_unused;
    logic [ADDR_W-1:0] raf_dout;
    logic              raf_full, raf_empty, raf_pop;
    logic [PW-1:0]     raf_count_unused;
    logic              rdf_full_unused, rdf_empty, rdf_push;
    logic [PW-1:0]     rdf_count;

    logic              outstanding;
    logic [PW:0]       credit_sum;
    logic              rd_credit;
    logic              grant_wr;
    logic              grant_rd;

    assign wf_din = '{addr: writeaddr, data: writedata};

    sync_fifo #(.WIDTH($bits(wr_entry_t)), .DEPTH(DEPTH)) u_wf (
        .clk(clk), .reset(reset),
        .push(write), .din(wf_din), .pop(wf_pop), .dout(wf_dout),
        .full(wf_full), .empty(wf_empty), .count(wf_count_unused)
    );

    sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_raf (
        .clk(clk), .reset(reset),
        .push(read), .din(readaddr), .pop(raf_pop), .dout(raf_dout),
        .full(raf_full), .empty(raf_empty), .count(raf_count_unused)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_rdf (
        .clk(clk), .reset(reset),
        .push(rdf_push), .din(mem_rdata), .pop(rd_pop), .dout(readdata),
        .full(rdf_full_unused), .empty(rdf_empty), .count(rdf_count)
    );

    // Read credit and write/read arbitration with alternating last-grant
    always_comb begin
        outstanding = (state_q == RD_REQ) || (state_q == RD_WAIT);
        credit_sum  = {1'b0, rdf_count} + {{PW{1'b0}}, outstanding};
        rd_credit   = !raf_empty && (credit_sum < (PW+1)'(DEPTH));
        grant_wr    = !wf_empty && (!rd_credit || !last_wr_q);
        grant_rd    = rd_credit && (wf_empty || last_wr_q);
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    state_d   = WR_REQ;
                    last_wr_d = 1'b1;
                end else if (grant_rd) begin
                    state_d   = RD_REQ;
                    last_wr_d = 1'b0;
                end
            end
            WR_REQ:  if (mem_ack)    state_d = IDLE;
            RD_REQ:  if (mem_ack)    state_d = RD_WAIT;
            RD_WAIT: if (mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath logic: load request registers, FIFO strobes, sticky overflow
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wf_pop      = 1'b0;
        raf_pop     = 1'b0;
        rdf_push    = 1'b0;
        overflow_d  = overflow_q | (write & wf_full) | (read & raf_full);
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wf_dout.addr;
                    mem_wdata_d = wf_dout.data;
                end else if (grant_rd) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = raf_dout;
                end
            end
            WR_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    wf_pop    = 1'b1;
                end
            end
            RD_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    raf_pop   = 1'b1;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    rdf_push = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_wr_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_wr_q   <= last_wr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            overflow_q  <= overflow_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign overflow  = overflow_q;
    assign wr_full   = wf_full;
    assign rd_empty  = rdf_empty;

endmodule

// File: tb/tb_vram_req_bridge.sv
// Self-checking bench for vram_req_bridge: a memory responder acks requests
// and returns read data, a scoreboard checks every accepted transaction.
`timescale 1ns/1ps
module tb_vram_req_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [15:0] writeaddr;
    logic [15:0] writedata;
    logic        wr_full;
    logic        read;
    logic [15:0] readaddr;
    logic        rd_pop;
    logic [15:0] readdata;
    logic        rd_empty;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        overflow;

    vram_req_bridge #(.ADDR_W(16), .DATA_W(16), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .write(write), .writeaddr(writeaddr), .writedata(writedata), .wr_full(wr_full),
        .read(read), .readaddr(readaddr), .rd_pop(rd_pop), .readdata(readdata), .rd_empty(rd_empty),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          ack_d;
        int          rv_d;
        logic [15:0] exp_rdata;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    txn_t        exp_txn[$];
    logic [15:0] exp_rd[$];
    bit          issued_we[$];
    logic [15:0] mem_model [logic [15:0]];
    int          done_cnt = 0;
    int          ack_dly = 0;
    int          rv_dly = 1;
    bit          ack_hold = 1'b0;
    bit          stray_en = 1'b0;
    vec_t        vecs[7];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Memory responder: acks after ack_dly waiting cycles, returns read data
    // rv_dly cycles after the ack, checks request stability and ordering.
    initial begin : responder
        int          wait_cnt;
        int          rv_cnt;
        bit          rv_pending;
        logic [15:0] rv_data;
        bit          prev_pend;
        logic [32:0] prev_req;
        txn_t        t;
        wait_cnt   = 0;
        rv_cnt     = 0;
        rv_pending = 1'b0;
        rv_data    = '0;
        prev_pend  = 1'b0;
        prev_req   = '0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_ack    = 1'b0;
            mem_rvalid = 1'b0;
            if (!reset) begin
                wait_cnt   = 0;
                rv_pending = 1'b0;
                prev_pend  = 1'b0;
            end else begin
                if (rv_pending) begin
                    if (rv_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rv_data;
                        rv_pending = 1'b0;
                    end else begin
                        rv_cnt--;
                    end
                end
                if (mem_req) begin
                    if (prev_pend) begin
                        checkOutput("mem_stable", 64'({mem_we, mem_addr, mem_wdata}), 64'(prev_req));
                    end
                    if (!ack_hold && wait_cnt >= ack_dly) begin
                        mem_ack   = 1'b1;
                        wait_cnt  = 0;
                        prev_pend = 1'b0;
                        issued_we.push_back(mem_we);
                        if (exp_txn.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_txn: got we=%0b addr=0x%0h expected none", mem_we, mem_addr);
                        end else begin
                            t = exp_txn.pop_front();
                            checkOutput("txn_we", 64'(mem_we), 64'(t.we));
                            checkOutput("txn_addr", 64'(mem_addr), 64'(t.addr));
                            if (t.we) checkOutput("txn_wdata", 64'(mem_wdata), 64'(t.data));
                        end
                        if (mem_we) begin
                            mem_model[mem_addr] = mem_wdata;
                        end else begin
                            rv_pending = 1'b1;
                            rv_cnt     = rv_dly - 1;
                            rv_data    = mem_model.exists(mem_addr) ? mem_model[mem_addr] : mem_addr;
                        end
                        done_cnt++;
                    end else begin
                        wait_cnt++;
                        prev_pend = 1'b1;
                        prev_req  = {mem_we, mem_addr, mem_wdata};
                        if (stray_en && mem_we && !mem_rvalid) begin
                            mem_rvalid = 1'b1;
                            mem_rdata  = 16'hBAD0;
                        end
                    end
                end else begin
                    wait_cnt  = 0;
                    prev_pend = 1'b0;
                end
            end
        end
    end

    // Drives one request cycle and records what the scoreboard should see
    task automatic applyStimulus(input bit do_wr, input logic [15:0] waddr, input logic [15:0] wdata,
                                 input bit do_rd, input logic [15:0] raddr,
                                 input bit wr_ok, input logic [15:0] exp_rdata);
        write     = do_wr;
        writeaddr = waddr;
        writedata = wdata;
        read      = do_rd;
        readaddr  = raddr;
        if (do_wr && wr_ok) exp_txn.push_back('{1'b1, waddr, wdata});
        if (do_rd) begin
            exp_txn.push_back('{1'b0, raddr, 16'h0000});
            exp_rd.push_back(exp_rdata);
        end
        @(negedge clk);
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic waitDone(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 64'(done_cnt >= target), 64'(1));
    endtask

    task automatic waitRdData(input int budget, input string name);
        int n = 0;
        while (rd_empty && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 64'(rd_empty), 64'(0));
    endtask

    task automatic popRead(input string name);
        logic [15:0] e;
        if (exp_rd.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got data 0x%0h expected no entry", name, readdata);
            return;
        end
        e = exp_rd.pop_front();
        checkOutput(name, 64'(readdata), 64'(e));
        rd_pop = 1'b1;
        @(negedge clk);
        rd_pop = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : main
        int base;
        reset     = 1'b0;
        write     = 1'b0;
        writeaddr = '0;
        writedata = '0;
        read      = 1'b0;
        readaddr  = '0;
        rd_pop    = 1'b0;

        vecs[0] = '{1'b1, 16'h0001, 16'h0001, 3, 1, 16'h0000};
        vecs[1] = '{1'b1, 16'h0010, 16'h1234, 0, 1, 16'h0000};
        vecs[2] = '{1'b0, 16'h0010, 16'h0000, 1, 1, 16'h1234};
        vecs[3] = '{1'b0, 16'h0003, 16'h0000, 0, 2, 16'h0003};
        vecs[4] = '{1'b1, 16'hFFFF, 16'hA5A5, 2, 1, 16'h0000};
        vecs[5] = '{1'b0, 16'hFFFF, 16'h0000, 2, 3, 16'hA5A5};
        vecs[6] = '{1'b0, 16'h8000, 16'h0000, 0, 1, 16'h8000};

        // Reset held while the client toggles requests
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            write     = i[0];
            read      = ~i[0];
            writeaddr = 16'(i);
            writedata = 16'(i + 7);
            readaddr  = 16'(i + 3);
        end
        @(negedge clk);
        checkOutput("rst_mem_req", 64'(mem_req), 64'(0));
        checkOutput("rst_mem_we", 64'(mem_we), 64'(0));
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'(0));
        checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        checkOutput("rst_overflow", 64'(overflow), 64'(0));
        checkOutput("rst_wr_full", 64'(wr_full), 64'(0));
        checkOutput("rst_rd_empty", 64'(rd_empty), 64'(1));
        checkOutput("rst_readdata", 64'(readdata), 64'(0));
        write = 1'b0;
        read  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick(3);
        checkOutput("post_rst_mem_req", 64'(mem_req), 64'(0));
        checkOutput("post_rst_rd_empty", 64'(rd_empty), 64'(1));
        checkOutput("post_rst_txns", 64'(done_cnt), 64'(0));

        // Write latency: request appears two cycles after the pulse
        ack_dly = 0;
        base    = done_cnt;
        applyStimulus(1'b1, 16'h0077, 16'h7777, 1'b0, 16'h0000, 1'b1, 16'h0000);
        checkOutput("wr_lat_early", 64'(mem_req), 64'(0));
        tick(1);
        checkOutput("wr_lat_req", 64'(mem_req), 64'(1));
        waitDone(base + 1, 20, "wr_lat_done");

        // Table of single transactions with varied ack/rvalid timing
        for (int v = 0; v < 7; v++) begin
            ack_dly = vecs[v].ack_d;
            rv_dly  = vecs[v].rv_d;
            base    = done_cnt;
            applyStimulus(vecs[v].is_wr, vecs[v].addr, vecs[v].data,
                          !vecs[v].is_wr, vecs[v].addr, 1'b1, vecs[v].exp_rdata);
            waitDone(base + 1, 40, "vec_done");
            if (vecs[v].is_wr) begin
                checkOutput("vec_wr_full", 64'(wr_full), 64'(0));
            end else begin
                waitRdData(40, "vec_rd_arrive");
                popRead("vec_rdata");
                checkOutput("vec_rd_empty", 64'(rd_empty), 64'(1));
            end
        end

        // Read latency: immediate ack and 1-cycle rvalid
        ack_dly = 0;
        rv_dly  = 1;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0055, 1'b1, 16'h0055);
        tick(2);
        checkOutput("rd_lat_early", 64'(rd_empty), 64'(1));
        tick(1);
        checkOutput("rd_lat_ready", 64'(rd_empty), 64'(0));
        popRead("rd_lat_rdata");

        // Write overflow: five back-to-back writes with the memory stalled
        ack_hold = 1'b1;
        base     = done_cnt;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'(32'h0100 + i), 16'(32'hC000 + i), 1'b0, 16'h0000,
                          (i < 4), 16'h0000);
            if (i == 3) begin
                checkOutput("ovf_full_after4", 64'(wr_full), 64'(1));
                checkOutput("ovf_not_yet", 64'(overflow), 64'(0));
            end
        end
        checkOutput("ovf_sticky", 64'(overflow), 64'(1));
        ack_dly  = 0;
        ack_hold = 1'b0;
        waitDone(base + 4, 60, "ovf_drain");
        tick(5);
        checkOutput("ovf_count", 64'(done_cnt), 64'(base + 4));
        checkOutput("ovf_full_clear", 64'(wr_full), 64'(0));
        checkOutput("ovf_still_set", 64'(overflow), 64'(1));

        // Credit throttle: four reads fill the read-data FIFO, fifth waits for a pop
        ack_dly = 0;
        rv_dly  = 1;
        base    = done_cnt;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 16'(32'h0040 + i), 1'b1, 16'(32'h0040 + i));
        end
        waitDone(base + 4, 60, "credit_four");
        tick(4);
        checkOutput("credit_rd_avail", 64'(rd_empty), 64'(0));
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0044, 1'b1, 16'h0044);
        tick(10);
        checkOutput("credit_hold", 64'(done_cnt), 64'(base + 4));
        checkOutput("credit_no_req", 64'(mem_req), 64'(0));
        popRead("credit_rd0");
        waitDone(base + 5, 30, "credit_fifth");
        for (int i = 0; i < 4; i++) begin
            waitRdData(20, "credit_drain_wait");
            popRead("credit_drain");
        end
        checkOutput("credit_empty", 64'(rd_empty), 64'(1));

        // Arbitration: writes and reads pending together, stray rvalid during writes
        ack_dly  = 1;
        rv_dly   = 1;
        stray_en = 1'b1;
        issued_we.delete();
        base = done_cnt;
        applyStimulus(1'b1, 16'h0200, 16'h1111, 1'b1, 16'h0200, 1'b1, 16'h1111);
        applyStimulus(1'b1, 16'h0201, 16'h2222, 1'b1, 16'h0201, 1'b1, 16'h2222);
        waitDone(base + 4, 80, "arb_done");
        stray_en = 1'b0;
        tick(4);
        checkOutput("arb_count", 64'(issued_we.size()), 64'(4));
        if (issued_we.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput("arb_order", 64'(issued_we[k]), 64'((k % 2) == 0));
            end
        end
        for (int i = 0; i < 2; i++) begin
            waitRdData(20, "arb_rd_wait");
            popRead("arb_rdata");
        end
        checkOutput("arb_no_stray", 64'(rd_empty), 64'(1));

        // Reset mid-transaction abandons the request and clears sticky state
        ack_hold = 1'b1;
        ack_dly  = 0;
        base     = done_cnt;
        applyStimulus(1'b1, 16'h0300, 16'h3333, 1'b0, 16'h0000, 1'b1, 16'h0000);
        tick(2);
        checkOutput("midrst_req_seen", 64'(mem_req), 64'(1));
        reset = 1'b0;
        exp_txn.delete();
        tick(2);
        checkOutput("midrst_mem_req", 64'(mem_req), 64'(0));
        checkOutput("midrst_overflow", 64'(overflow), 64'(0));
        reset    = 1'b1;
        ack_hold = 1'b0;
        tick(6);
        checkOutput("midrst_no_txn", 64'(done_cnt), 64'(base));
        checkOutput("midrst_idle", 64'(mem_req), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
